// File: rtl/hera_lsu_if.sv
// Data-memory bus between the LSU (master) and memory (slave).
// Single outstanding request; mem_rdata is valid only while mem_ack is high.
interface hera_lsu_if #(
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_ack, mem_rdata);
endinterface

// File: rtl/hera_lsu.sv
// HERA load/store unit: one memory access per instruction.
// Accepts in IDLE, holds the request in ACCESS until ack or timeout.
// load_en pulses in the ack cycle; load is registered and valid the cycle after.
module hera_lsu #(
  parameter int DATA_W  = 16,
  parameter int OFF_W   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic              st_en,
  input  logic [3:0]        rd,
  input  logic [DATA_W-1:0] base,
  input  logic [DATA_W-1:0] st_data,
  input  logic [OFF_W-1:0]  offset,
  output logic              stall,
  output logic              load_en,
  output logic [DATA_W-1:0] load,
  output logic [3:0]        load_rd,
  output logic              err,
  hera_lsu_if.master        mem
);

  typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  // Counter value at which the current ACCESS cycle is the last one allowed.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              is_ld;
  logic [7:0]        cnt;
  logic              req_q, we_q;
  logic [DATA_W-1:0] addr_q, wdata_q;
  logic              accept, done, expire;

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and the combinational handshake outputs (stall, load_en).
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done    = 1'b0;
    expire  = 1'b0;
    stall   = 1'b0;
    load_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_en || st_en) begin
          accept  = 1'b1;
          stall   = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Ack wins over an expiry landing in the same cycle.
        if (mem.mem_ack) begin
          done    = 1'b1;
          load_en = is_ld;
          state_d = IDLE;
        end else if (cnt == TO_LAST) begin
          expire  = 1'b1;
          state_d = IDLE;
        end else begin
          stall   = 1'b1;
        end
      end
    endcase
    // Outputs read zero for the whole time reset is held, even with an op on the inputs.
    if (!rst) begin
      stall   = 1'b0;
      load_en = 1'b0;
    end
  end

  // Op capture, request/timeout bookkeeping and the load data register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_ld   <= 1'b0;
      cnt     <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      load    <= '0;
      load_rd <= '0;
      err     <= 1'b0;
    end else if (accept) begin
      is_ld   <= ld_en;
      load_rd <= rd;
      addr_q  <= base + DATA_W'(offset);
      wdata_q <= st_data;
      we_q    <= ~ld_en & st_en;
      req_q   <= 1'b1;
      cnt     <= '0;
    end else if (state_q == ACCESS) begin
      if (done) begin
        req_q <= 1'b0;
        if (is_ld) load <= mem.mem_rdata;
      end else if (expire) begin
        req_q <= 1'b0;
        err   <= 1'b1;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_hera_lsu.sv
// Bench for hera_lsu: directed scenarios with a queue of expected load values.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_hera_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic        ld_en, st_en;
  logic [3:0]  rd;
  logic [15:0] base, st_data;
  logic [4:0]  offset;
  logic        stall, load_en, err;
  logic [15:0] load;
  logic [3:0]  load_rd;

  hera_lsu_if #(.DATA_W(16)) mif ();

  hera_lsu #(.DATA_W(16), .OFF_W(5), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .st_en(st_en), .rd(rd),
    .base(base), .st_data(st_data), .offset(offset),
    .stall(stall), .load_en(load_en), .load(load), .load_rd(load_rd),
    .err(err), .mem(mif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;
  int pulses = 0;
  bit le_prev = 0;
  bit le_double = 0;

  // Counts load_en pulses and flags any pulse longer than one cycle.
  always @(negedge clk) begin
    if (load_en) pulses++;
    if (load_en && le_prev) le_double = 1;
    le_prev = load_en;
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; ld_en = 0; st_en = 0; rd = 0; base = 0; st_data = 0; offset = 0;
    mif.mem_ack = 0; mif.mem_rdata = 0;
    #2;
    n_cmp++;
    if ({mif.mem_req, mif.mem_we, stall, load_en, err} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 00000", {mif.mem_req, mif.mem_we, stall, load_en, err});
    end
    n_cmp++;
    if ({load, load_rd, mif.mem_addr, mif.mem_wdata} !== 52'h0) begin
      n_err++; $display("FAIL reset_data: got %h want 0", {load, load_rd, mif.mem_addr, mif.mem_wdata});
    end
    tick; rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick; @(negedge clk);
      n_cmp++;
      if ({mif.mem_req, stall} !== 2'b00) begin
        n_err++; $display("FAIL reset_idle: cycle %0d got req/stall %b want 00", i, {mif.mem_req, stall});
      end
    end
  endtask

  task automatic test_zero_wait_load;
    int p0 = pulses;
    tick; ld_en = 1; base = 16'h0100; offset = 5'd3; rd = 4'h5;
    exp_q.push_back(16'hBEEF);
    @(negedge clk);
    n_cmp++;
    if ({stall, load_en} !== 2'b10) begin
      n_err++; $display("FAIL zw_accept: stall/load_en %b want 10", {stall, load_en});
    end
    tick; mif.mem_ack = 1; mif.mem_rdata = 16'hBEEF;
    @(negedge clk);
    n_cmp++;
    if ({mif.mem_req, mif.mem_we, stall, load_en} !== 4'b1001) begin
      n_err++; $display("FAIL zw_ack: req/we/stall/load_en %b want 1001", {mif.mem_req, mif.mem_we, stall, load_en});
    end
    n_cmp++;
    if (mif.mem_addr !== 16'h0103 || load_rd !== 4'h5) begin
      n_err++; $display("FAIL zw_addr: addr %h rd %h want 0103 5", mif.mem_addr, load_rd);
    end
    tick; mif.mem_ack = 0; mif.mem_rdata = 16'h0; ld_en = 0;
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (load !== exp_v || load_en !== 1'b0 || mif.mem_req !== 1'b0 || stall !== 1'b0) begin
      n_err++; $display("FAIL zw_data: load %h en %b req %b stall %b want %h 0 0 0", load, load_en, mif.mem_req, stall, exp_v);
    end
    n_cmp++;
    if (pulses - p0 !== 1) begin
      n_err++; $display("FAIL zw_pulses: got %0d want 1", pulses - p0);
    end
  endtask

  task automatic test_wait_store;
    int p0 = pulses;
    int nstall = 0;
    tick; st_en = 1; base = 16'hFFFE; offset = 5'd4; st_data = 16'h1234; rd = 4'h9;
    @(negedge clk); if (stall) nstall++;
    for (int i = 0; i < 3; i++) begin
      tick; @(negedge clk); if (stall) nstall++;
      n_cmp++;
      if ({mif.mem_req, mif.mem_we} !== 2'b11 || mif.mem_addr !== 16'h0002 || mif.mem_wdata !== 16'h1234) begin
        n_err++; $display("FAIL st_hold: cycle %0d req/we %b addr %h wdata %h want 11 0002 1234", i, {mif.mem_req, mif.mem_we}, mif.mem_addr, mif.mem_wdata);
      end
    end
    tick; mif.mem_ack = 1; mif.mem_rdata = 16'h5555;
    @(negedge clk); if (stall) nstall++;
    n_cmp++;
    if ({stall, load_en} !== 2'b00) begin
      n_err++; $display("FAIL st_ack: stall/load_en %b want 00", {stall, load_en});
    end
    tick; mif.mem_ack = 0; st_en = 0;
    @(negedge clk);
    n_cmp++;
    if (nstall !== 4) begin
      n_err++; $display("FAIL st_stall_cycles: got %0d want 4", nstall);
    end
    n_cmp++;
    if (load !== 16'hBEEF || pulses - p0 !== 0 || err !== 1'b0 || mif.mem_req !== 1'b0) begin
      n_err++; $display("FAIL st_no_load: load %h pulses %0d err %b req %b want BEEF 0 0 0", load, pulses - p0, err, mif.mem_req);
    end
  endtask

  task automatic test_back_to_back;
    int p0 = pulses;
    tick; ld_en = 1; base = 16'h0010; offset = 5'd0;
    exp_q.push_back(16'h0001);
    tick; mif.mem_ack = 1; mif.mem_rdata = 16'h0001;
    @(negedge clk);
    n_cmp++;
    if (load_en !== 1'b1) begin
      n_err++; $display("FAIL b2b_en1: got %b want 1", load_en);
    end
    tick; mif.mem_ack = 0; base = 16'h0020; offset = 5'd1;
    exp_q.push_back(16'h0000);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (load !== exp_v || {stall, load_en} !== 2'b10) begin
      n_err++; $display("FAIL b2b_first: load %h stall/en %b want %h 10", load, {stall, load_en}, exp_v);
    end
    tick; mif.mem_ack = 1; mif.mem_rdata = 16'h0000;
    @(negedge clk);
    n_cmp++;
    if (load_en !== 1'b1 || mif.mem_addr !== 16'h0021) begin
      n_err++; $display("FAIL b2b_en2: en %b addr %h want 1 0021", load_en, mif.mem_addr);
    end
    tick; mif.mem_ack = 0; ld_en = 0;
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (load !== exp_v || pulses - p0 !== 2) begin
      n_err++; $display("FAIL b2b_second: load %h pulses %0d want %h 2", load, pulses - p0, exp_v);
    end
  endtask

  task automatic test_both_and_stray;
    tick; ld_en = 1; st_en = 1; base = 16'h0040; offset = 5'h1F; st_data = 16'h7777;
    exp_q.push_back(16'hA5A5);
    tick; mif.mem_ack = 1; mif.mem_rdata = 16'hA5A5;
    @(negedge clk);
    n_cmp++;
    if (mif.mem_we !== 1'b0 || mif.mem_addr !== 16'h005F || load_en !== 1'b1) begin
      n_err++; $display("FAIL both_load: we %b addr %h en %b want 0 005F 1", mif.mem_we, mif.mem_addr, load_en);
    end
    tick; ld_en = 0; st_en = 0; mif.mem_ack = 1; mif.mem_rdata = 16'hFFFF;
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (load !== exp_v) begin
      n_err++; $display("FAIL both_data: got %h want %h", load, exp_v);
    end
    tick;
    @(negedge clk);
    n_cmp++;
    if ({mif.mem_req, stall, load_en} !== 3'b000 || load !== 16'hA5A5) begin
      n_err++; $display("FAIL stray_ack: req/stall/en %b load %h want 000 A5A5", {mif.mem_req, stall, load_en}, load);
    end
    tick; mif.mem_ack = 0; mif.mem_rdata = 16'h0;
  endtask

  task automatic test_timeout;
    int p0 = pulses;
    int nreq = 0;
    tick; ld_en = 1; base = 16'h0200; offset = 5'd0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      tick; if (i == 4) ld_en = 0;
      @(negedge clk);
      if (mif.mem_req) nreq++;
      if (i <= 3) begin
        n_cmp++;
        if (stall !== (i < 3)) begin
          n_err++; $display("FAIL to_stall: cycle %0d got %b want %b", i, stall, (i < 3));
        end
      end
    end
    n_cmp++;
    if (nreq !== 4) begin
      n_err++; $display("FAIL to_req_cycles: got %0d want 4", nreq);
    end
    n_cmp++;
    if (err !== 1'b1 || mif.mem_req !== 1'b0 || pulses - p0 !== 0 || load !== 16'hA5A5) begin
      n_err++; $display("FAIL to_abort: err %b req %b pulses %0d load %h want 1 0 0 A5A5", err, mif.mem_req, pulses - p0, load);
    end
  endtask

  task automatic test_reset_mid;
    int p0 = pulses;
    tick; ld_en = 1; base = 16'h0300; offset = 5'd2; rd = 4'hC;
    tick;
    @(negedge clk);
    n_cmp++;
    if (mif.mem_req !== 1'b1) begin
      n_err++; $display("FAIL rm_pre: req %b want 1", mif.mem_req);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({mif.mem_req, mif.mem_we, stall, load_en, err} !== 5'b0 ||
        {load, load_rd, mif.mem_addr, mif.mem_wdata} !== 52'h0) begin
      n_err++; $display("FAIL rm_clear: ctrl %b data %h want 0", {mif.mem_req, mif.mem_we, stall, load_en, err},
                        {load, load_rd, mif.mem_addr, mif.mem_wdata});
    end
    tick; ld_en = 0; mif.mem_ack = 1;
    tick; rst = 1'b1;
    tick; mif.mem_ack = 0;
    @(negedge clk);
    n_cmp++;
    if ({mif.mem_req, stall, err} !== 3'b000 || pulses - p0 !== 0) begin
      n_err++; $display("FAIL rm_after: req/stall/err %b pulses %0d want 000 0", {mif.mem_req, stall, err}, pulses - p0);
    end
  endtask

  initial begin
    test_reset;
    test_zero_wait_load;
    test_wait_store;
    test_back_to_back;
    test_both_and_stray;
    test_timeout;
    test_reset_mid;
    n_cmp++;
    if (le_double !== 1'b0 || exp_q.size() !== 0) begin
      n_err++; $display("FAIL pulse_width: double %b leftover %0d want 0 0", le_double, exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
